// File: rtl/serial_add_pkg.sv
// Shared types and constants for the bit-serial add/subtract sequencer.
// State encoding is fixed so debug taps stay readable across revisions.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    // Two's-complement subtract: invert B and inject a carry of one.
    localparam logic SUB_CIN = 1'b1;

endpackage

// File: rtl/fa_cell.sv
// Single 1-bit full adder: the only arithmetic in the serial datapath.
module fa_cell (
    input  logic x,
    input  logic y,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = x ^ y ^ ci;
    assign co = (x & y) | (x & ci) | (y & ci);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer: steps one full-adder cell LSB-first,
// one bit per clock, and presents sum/cout/ovf with a one-cycle done pulse.
module serial_add_ctrl
    import serial_add_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output state_t           dbg_state
);

    // Handshake: an operation is accepted on a rising edge where start=1 and
    // ready=1 (IDLE only); done qualifies sum/cout/ovf for exactly that cycle,
    // and the result is then held until the next accepted start.

    localparam logic [CNT_W-1:0] LAST_IDX   = CNT_W'(WIDTH - 1);
    localparam logic [CNT_W-1:0] MSB_IN_IDX = CNT_W'(WIDTH - 2);

    state_t             state;
    state_t             state_next;
    logic [WIDTH-1:0]   op_a;
    logic [WIDTH-1:0]   op_b;
    logic [WIDTH-1:0]   res_sr;
    logic               carry;
    logic               c_msb_in;
    logic [CNT_W-1:0]   idx;
    logic               cell_s;
    logic               cell_co;

    fa_cell u_fa_cell (
        .x  (op_a[0]),
        .y  (op_b[0]),
        .ci (carry),
        .s  (cell_s),
        .co (cell_co)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (idx == LAST_IDX) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        ready     = (state == IDLE);
        busy      = (state == RUN);
        done      = (state == DONE);
        dbg_state = state;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_a     <= '0;
            op_b     <= '0;
            res_sr   <= '0;
            carry    <= 1'b0;
            c_msb_in <= 1'b0;
            idx      <= '0;
            sum      <= '0;
            cout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        op_a   <= a;
                        op_b   <= sub ? ~b : b;
                        carry  <= sub ? SUB_CIN : cin;
                        idx    <= '0;
                        res_sr <= '0;
                    end
                end
                RUN: begin
                    op_a   <= op_a >> 1;
                    op_b   <= op_b >> 1;
                    carry  <= cell_co;
                    res_sr <= {cell_s, res_sr[WIDTH-1:1]};
                    if (idx == MSB_IN_IDX) begin
                        c_msb_in <= cell_co;
                    end
                    // Final bit: publish the result and park the counter at 0.
                    if (idx == LAST_IDX) begin
                        idx  <= '0;
                        sum  <= {cell_s, res_sr[WIDTH-1:1]};
                        cout <= cell_co;
                        ovf  <= c_msb_in ^ cell_co;
                    end else begin
                        idx <= idx + CNT_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: directed cases plus random
// operations against an arithmetic reference and a cycle-level timing model.
module tb_serial_add_ctrl;
    import serial_add_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic         sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ready;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    state_t       dbg_state;

    int n_tests = 0;
    int n_fail  = 0;

    serial_add_ctrl #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .sub       (sub),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .ready     (ready),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf),
        .dbg_state (dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference arithmetic: {cout, ovf, sum} from plain integer addition.
    function automatic logic [W+1:0] ref_op(input logic [W-1:0] ra, input logic [W-1:0] rb,
                                            input logic rs, input logic rc);
        logic [W-1:0] bb;
        logic [W:0]   full;
        logic         v;
        bb   = rs ? ~rb : rb;
        full = {1'b0, ra} + {1'b0, bb} + (W+1)'(rs ? 1'b1 : rc);
        v    = (ra[W-1] == bb[W-1]) && (full[W-1] != ra[W-1]);
        return {full[W], v, full[W-1:0]};
    endfunction

    // Timing model: cycles remaining until IDLE (0 = idle, 1 = done cycle).
    int              m_cnt = 0;
    logic [W+1:0]    exp_q[$];
    logic [W+1:0]    m_res = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_cnt = 0;
            exp_q.delete();
            m_res = '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                exp_q.push_back(ref_op(a, b, sub, cin));
                m_cnt = W + 1;
            end
        end else begin
            m_cnt--;
            if (m_cnt == 1 && exp_q.size() > 0) m_res = exp_q.pop_front();
        end
    end

    // scoreboard: compare every cycle once reset has settled
    bit chk_en   = 1'b0;
    int cyc      = 0;
    int done_cnt = 0;
    int done_cyc[$];

    always @(negedge clk) begin
        if (chk_en) begin
            cyc++;
            check("ready", 32'(ready), 32'(m_cnt == 0));
            check("busy", 32'(busy), 32'(m_cnt >= 2));
            check("done", 32'(done), 32'(m_cnt == 1));
            check("state", 32'(dbg_state),
                  32'((m_cnt == 0) ? IDLE : (m_cnt == 1) ? DONE : RUN));
            check("result", 32'({cout, ovf, sum}), 32'(m_res));
            if (done) begin
                done_cnt++;
                done_cyc.push_back(cyc);
            end
        end
    end

    // driver
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                          input logic os, input logic oc,
                          input logic [W-1:0] xs, input logic xc, input logic xo,
                          input bit fixed);
        int lat;
        int guard;
        guard = 0;
        while (!ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!ready) check("ready_wait", 32'(ready), 32'd1);
        a = oa; b = ob; sub = os; cin = oc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); cin = 1'($urandom);
        lat = 1;
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
        end
        check("latency", 32'(lat), 32'(W + 1));
        if (fixed) begin
            check("sum", 32'(sum), 32'(xs));
            check("cout", 32'(cout), 32'(xc));
            check("ovf", 32'(ovf), 32'(xo));
        end
        @(negedge clk);
        check("ready_after", 32'(ready), 32'd1);
    endtask

    initial begin
        int n0;
        rst = 1'b1; start = 1'b0; sub = 1'b0; cin = 1'b0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        chk_en = 1'b1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_cout", 32'(cout), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        run_op(8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b1, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0, 1'b1);
        run_op(8'h10, 8'h01, 1'b1, 1'b0, 8'h0F, 1'b1, 1'b0, 1'b1);
        run_op(8'h80, 8'h01, 1'b1, 1'b1, 8'h7F, 1'b1, 1'b1, 1'b1);
        run_op(8'h00, 8'h01, 1'b1, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1);

        // start pulsed again mid-RUN with new operands must be ignored
        n0 = done_cnt;
        a = 8'h01; b = 8'h01; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'hAA; b = 8'h55; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (12) @(negedge clk);
        check("busy_start_sum", 32'(sum), 32'h02);
        check("busy_start_dones", 32'(done_cnt - n0), 32'd1);

        // reset in the middle of RUN aborts without a done pulse
        a = 8'h33; b = 8'h44; sub = 1'b0; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_sum", 32'(sum), 32'd0);
        rst = 1'b0;
        n0 = done_cnt;
        repeat (12) @(negedge clk);
        check("abort_no_done", 32'(done_cnt - n0), 32'd0);
        run_op(8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, 1'b0, 1'b1);

        // start held high: one accept every W+2 cycles
        done_cyc.delete();
        a = 8'h01; b = 8'h02; sub = 1'b0; cin = 1'b0; start = 1'b1;
        repeat (25) @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("b2b_count", 32'(done_cyc.size()), 32'd3);
        for (int i = 1; i < done_cyc.size(); i++) begin
            check("b2b_spacing", 32'(done_cyc[i] - done_cyc[i-1]), 32'(W + 2));
        end
        check("b2b_sum", 32'(sum), 32'h03);

        // random operations against the reference model
        for (int i = 0; i < 30; i++) begin
            repeat ($urandom_range(0, 3)) @(negedge clk);
            run_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                   '0, 1'b0, 1'b0, 1'b0);
        end

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_add_ctrl.md
Name: serial_add_ctrl

Overview:
- Bit-serial add/subtract engine built around a single 1-bit full-adder cell.
- Accepts two WIDTH-bit operands on a start handshake and steps the cell LSB-first, one bit per clock, with a registered carry.
- Presents the sum, carry-out and signed overflow together with a one-cycle done pulse.
- Sits beside the combinational adder library as the area-minimal sequencer for that datapath.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH), bit-index counter width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous reset, active-high.
- start  input  1  request a new operation; sampled only while ready=1.
- sub  input  1  0 = A+B+cin, 1 = A−B (B inverted, cin forced to 1); captured at start.
- a  input  WIDTH  operand A, captured at start.
- b  input  WIDTH  operand B, captured at start.
- cin  input  1  carry-in for add mode; ignored when sub=1.
- ready  output  1  high in IDLE only.
- busy  output  1  high in RUN only.
- done  output  1  one-cycle pulse; sum/cout/ovf valid.
- sum  output  WIDTH  result; held until the next accepted start.
- cout  output  1  final carry (sub mode: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- All state changes occur on the rising edge of clk; rst is sampled there.
- Reset: state=IDLE, ready=1, busy=0, done=0, sum=0, cout=0, ovf=0, counter=0, internal shift/carry registers=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start=1 → RUN.
  - Load opA←a and opB←(sub ? ~b : b).
  - Load carry←(sub ? 1 : cin).
  - Set idx←0.
  - Clear the result shift register.
- RUN, each edge:
  - The cell computes s=opA[0]^opB[0]^carry and c=majority(opA[0],opB[0],carry).
  - Shift s into the result MSB (shift right).
  - Shift opA and opB right by 1; carry←c; idx←idx+1.
  - When idx==WIDTH-2, also latch the cell carry-out as c_msb_in (carry into MSB).
  - On the edge where idx==WIDTH-1: → DONE.
  - That same edge loads sum←final shift register, cout←c, ovf←c_msb_in^c.
- DONE: done=1 for exactly one cycle, then → IDLE unconditionally.
- Latency: start sampled at edge E0; done is high in the cycle following edge E(WIDTH). Total is WIDTH+1 cycles from start edge to done.
- Throughput: one operation per WIDTH+2 cycles.
- start while busy or in DONE is ignored (not queued). Operand/sub/cin changes after capture have no effect.
- sum/cout/ovf change only on the edge that enters DONE, and remain stable through IDLE.
- rst mid-RUN: abort immediately to the reset values. No done pulse is issued for the aborted operation.
- rst and start asserted on the same edge: rst wins; start is lost.
- Width: all arithmetic is modulo 2^WIDTH. idx never exceeds WIDTH-1; the counter wraps to 0 on entry to RUN.

Decomposition:
- Shared package serial_add_pkg:
  - FSM state enum {IDLE, RUN, DONE} (2-bit encoding 00/01/10).
  - Constant SUB_CIN = 1'b1.
- One natural sub-module: fa_cell. It is a purely combinational 1-bit full adder (x, y, ci → s, co), instantiated once.
- FSM, counter and shift registers stay in serial_add_ctrl.

Test Plan (WIDTH=8):
- Add with signed overflow: a=0x5A, b=0x3C, sub=0, cin=0, start 1 cycle → done 9 cycles after start edge, sum=0x96, cout=0, ovf=1; ready returns high the next cycle.
- Unsigned wrap: a=0xFF, b=0x01, cin=0 → sum=0x00, cout=1, ovf=0. Same with cin=1 → sum=0x01, cout=1.
- Subtract: a=0x10, b=0x01, sub=1 → sum=0x0F, cout=1, ovf=0. Then a=0x80, b=0x01, sub=1 → sum=0x7F, cout=1, ovf=1. Then a=0x00, b=0x01 → sum=0xFF, cout=0.
- Start during RUN: start a=0x01, b=0x01; pulse start again at cycle 3 with a=0xAA → ignored; result sum=0x02 with a single done pulse. Operands changed mid-RUN also do not alter the result.
- Reset mid-operation: assert rst at cycle 4 of RUN → next cycle ready=1, busy=0, done=0, sum=0. No done pulse appears. A subsequent 0x22+0x11 yields 0x33 normally.
- Back-to-back: hold start=1 continuously with a=0x01, b=0x02 → ops accepted every 10 cycles, done pulses spaced 10 cycles apart, sum=0x03 each time.
